// File: rtl/icache_fetch_controller.sv
// Direct-mapped instruction cache fetch sequencer.
// Ports: clock/reset, pc+fetch_req/fetch_ready, instruction/instr_valid/fetch_fault,
//   flush, mem_req/mem_addr/mem_ack/mem_data refill, hit_count/miss_count.
module icache_fetch_controller #(
  parameter int SETS        = 16,
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 3,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_req,
  output logic        fetch_ready,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        fetch_fault,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

  state_t state, nextState;

  logic [31:OFFSET_BITS] pcBlock;
  logic [SETS-1:0]       validBits;
  logic [TAG_BITS-1:0]   tagArray [SETS];
  logic [31:0]           dataArray [SETS];
  logic [TW-1:0]         timeoutCount;
  logic                  flushPending;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  timedOut;
  logic                  install;
  logic                  unusedPcBits;

  assign unusedPcBits = ^pc[OFFSET_BITS-1:0];

  assign index = pcBlock[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign tag = pcBlock[31:OFFSET_BITS+INDEX_BITS];
  assign hit = validBits[index] && (tagArray[index] == tag);
  assign timedOut = (timeoutCount == TW'(MEM_TIMEOUT - 1));
  // A flush seen before or alongside the ack keeps the line out of the cache.
  assign install = mem_ack && !flushPending && !flush;

  assign fetch_ready = (state == IDLE) && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (fetch_req && fetch_ready) nextState = LOOKUP;
      LOOKUP:  nextState = hit ? IDLE : REFILL;
      REFILL:  if (mem_ack || timedOut) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcBlock      <= '0;
      validBits    <= '0;
      instruction  <= '0;
      instr_valid  <= 1'b0;
      fetch_fault  <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      flushPending <= 1'b0;
      timeoutCount <= '0;
    end else begin
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req && fetch_ready) pcBlock <= pc[31:OFFSET_BITS];
        end
        LOOKUP: begin
          if (hit) begin
            instruction <= dataArray[index];
            instr_valid <= 1'b1;
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
          end else begin
            mem_req      <= 1'b1;
            mem_addr     <= {pcBlock, {OFFSET_BITS{1'b0}}};
            timeoutCount <= '0;
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
          end
        end
        REFILL: begin
          if (flush) flushPending <= 1'b1;
          if (mem_ack) begin
            instruction  <= mem_data;
            instr_valid  <= 1'b1;
            mem_req      <= 1'b0;
            flushPending <= 1'b0;
            if (install) validBits[index] <= 1'b1;
          end else if (timedOut) begin
            instruction  <= 32'hDEAD_BEEF;
            instr_valid  <= 1'b1;
            fetch_fault  <= 1'b1;
            mem_req      <= 1'b0;
            flushPending <= 1'b0;
          end else begin
            timeoutCount <= timeoutCount + TW'(1);
          end
        end
        default: ;
      endcase
      // Clears last so it overrides any same-cycle valid update.
      if (flush) validBits <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (state == REFILL && install) begin
      tagArray[index]  <= tag;
      dataArray[index] <= mem_data;
    end
  end

endmodule

// File: tb/tb_icache_fetch_controller.sv
// Scoreboarded directed bench for icache_fetch_controller.
// Stimulus pushes expected returns; a negedge monitor pops and compares.
module tb_icache_fetch_controller;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_req;
  logic        fetch_ready;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        fetch_fault;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int tests = 0;
  int fails = 0;
  logic [32:0] expQ [$];

  icache_fetch_controller dut (
    .clock(clock), .reset(reset), .pc(pc),
    .fetch_req(fetch_req), .fetch_ready(fetch_ready),
    .instruction(instruction), .instr_valid(instr_valid),
    .fetch_fault(fetch_fault), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && instr_valid) begin
      logic [32:0] e;
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_instr_valid: got %h want none", instruction);
      end else begin
        e = expQ.pop_front();
        check("instruction", instruction, e[31:0]);
        check("fetch_fault", {31'd0, fetch_fault}, {31'd0, e[32]});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a);
    pc = a;
    fetch_req = 1'b1;
    #1;
    check("fetch_ready", {31'd0, fetch_ready}, 32'd1);
    @(posedge clock);
    #1;
    fetch_req = 1'b0;
  endtask

  task automatic missRefill(input logic [31:0] a, input logic [31:0] d,
                            input int delay);
    issue(a);
    step();
    check("miss_mem_req", {31'd0, mem_req}, 32'd1);
    check("miss_mem_addr", mem_addr, a & 32'hFFFF_FFF8);
    repeat (delay) step();
    mem_ack = 1'b1;
    mem_data = d;
    expQ.push_back({1'b0, d});
    step();
    mem_ack = 1'b0;
    check("refill_mem_req_drop", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic hitFetch(input logic [31:0] a, input logic [31:0] d);
    issue(a);
    expQ.push_back({1'b0, d});
    step();
    check("hit_latency_valid", {31'd0, instr_valid}, 32'd1);
    check("hit_no_mem_req", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pc = '0;
    fetch_req = 1'b0;
    flush = 1'b0;
    mem_ack = 1'b0;
    mem_data = '0;
    #1;
    check("rst_instruction", instruction, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_counts", {hit_count, miss_count}, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    step();

    missRefill(32'h100, 32'h9100_06D6, 3);
    check("miss_count_1", {16'd0, miss_count}, 32'd1);
    hitFetch(32'h104, 32'h9100_06D6);
    check("hit_count_1", {16'd0, hit_count}, 32'd1);

    missRefill(32'h180, 32'hEA15_0289, 2);
    hitFetch(32'h180, 32'hEA15_0289);
    check("hit_count_2", {16'd0, hit_count}, 32'd2);
    missRefill(32'h100, 32'h9100_06D6, 0);
    check("miss_count_3", {16'd0, miss_count}, 32'd3);

    issue(32'h208);
    step();
    check("to_mem_req", {31'd0, mem_req}, 32'd1);
    expQ.push_back({1'b1, 32'hDEAD_BEEF});
    repeat (63) step();
    check("to_mem_req_held", {31'd0, mem_req}, 32'd1);
    step();
    check("to_mem_req_drop", {31'd0, mem_req}, 32'd0);
    check("to_fault_pulse", {31'd0, fetch_fault}, 32'd1);
    step();
    check("to_fault_one_cycle", {31'd0, fetch_fault}, 32'd0);
    missRefill(32'h208, 32'h1234_5678, 1);
    check("miss_count_5", {16'd0, miss_count}, 32'd5);
    hitFetch(32'h20C, 32'h1234_5678);
    check("hit_count_3", {16'd0, hit_count}, 32'd3);

    issue(32'h310);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    mem_ack = 1'b1;
    mem_data = 32'hCAFE_F00D;
    expQ.push_back({1'b0, 32'hCAFE_F00D});
    step();
    mem_ack = 1'b0;
    missRefill(32'h310, 32'hCAFE_F00D, 0);
    missRefill(32'h208, 32'h1234_5678, 0);
    check("miss_count_8", {16'd0, miss_count}, 32'd8);

    pc = 32'h310;
    fetch_req = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_blocks_ready", {31'd0, fetch_ready}, 32'd0);
    step();
    fetch_req = 1'b0;
    flush = 1'b0;
    step();
    check("flush_req_not_taken", {31'd0, mem_req}, 32'd0);
    missRefill(32'h310, 32'hCAFE_F00D, 0);
    check("miss_count_9", {16'd0, miss_count}, 32'd9);

    issue(32'h400);
    step();
    check("rr_mem_req", {31'd0, mem_req}, 32'd1);
    repeat (2) step();
    reset = 1'b1;
    #1;
    check("rr_mem_req_async", {31'd0, mem_req}, 32'd0);
    check("rr_mem_addr", mem_addr, 32'd0);
    check("rr_counts", {hit_count, miss_count}, 32'd0);
    check("rr_instruction", instruction, 32'd0);
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_data = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    step();
    check("rr_stray_ack_mem_req", {31'd0, mem_req}, 32'd0);
    missRefill(32'h400, 32'h0BAD_C0DE, 1);
    check("rr_miss_count", {16'd0, miss_count}, 32'd1);

    repeat (3) step();
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL missing_instr_valid: got %0d pending want 0",
               expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
